// File: rtl/sample_dma.sv
// Write-only Wishbone master that streams 32-bit samples into a circular SRAM buffer.
// A small input FIFO absorbs arbiter latency; half/wrap pulses notify the consumer.
module sample_dma #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int unsigned WORDS      = 512,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst_n,
  input  logic                     enable,
  input  logic                     s_stb,
  input  logic [31:0]              s_data,
  input  logic                     clr_ovf,
  output logic                     wb_cyc,
  output logic                     wb_we,
  output logic [3:0]               wb_sel,
  output logic [31:0]              wb_adr,
  output logic [31:0]              wb_dat,
  input  logic                     wb_ack,
  output logic [$clog2(WORDS)-1:0] wr_idx,
  output logic                     half,
  output logic                     wrap,
  output logic                     overflow
);

  localparam int unsigned IW = $clog2(WORDS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StBus, StGap} state_e;

  state_e          r_state;
  state_e          w_state_d;

  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            r_cyc;
  logic [31:0]     r_adr;
  logic [31:0]     r_dat;
  logic [IW-1:0]   r_idx;
  logic            r_half;
  logic            r_wrap;
  logic            r_ovf;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_ack_done;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
  assign w_push     = s_stb & enable & ~w_full;
  assign w_ack_done = (r_state == StBus) & wb_ack;

  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    case (r_state)
      StIdle: begin
        if (enable && !w_empty) begin
          w_pop     = 1'b1;
          w_state_d = StBus;
        end
      end
      StBus:   if (wb_ack) w_state_d = StGap;
      StGap:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) r_state <= StIdle;
    else           r_state <= w_state_d;
  end

  // Storage needs no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge wb_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (!enable) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_cyc <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
    end else if (w_pop) begin
      r_cyc <= 1'b1;
      r_adr <= BASE + (32'(r_idx) << 2);
      r_dat <= r_mem[r_rd_ptr];
    end else if (w_ack_done) begin
      r_cyc <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_idx  <= '0;
      r_half <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_half <= w_ack_done && (r_idx == IW'(WORDS / 2 - 1));
      r_wrap <= w_ack_done && (r_idx == IW'(WORDS - 1));
      if (w_ack_done) begin
        r_idx <= enable ? r_idx + IW'(1) : '0;
      end else if (!enable && r_state != StBus) begin
        // An in-flight write keeps its index until it is acked.
        r_idx <= '0;
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n)                    r_ovf <= 1'b0;
    else if (s_stb && enable && w_full) r_ovf <= 1'b1;
    else if (clr_ovf)                 r_ovf <= 1'b0;
  end

  assign wb_cyc   = r_cyc;
  assign wb_we    = r_cyc;
  assign wb_sel   = {4{r_cyc}};
  assign wb_adr   = r_adr;
  assign wb_dat   = r_dat;
  assign wr_idx   = r_idx;
  assign half     = r_half;
  assign wrap     = r_wrap;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_sample_dma.sv
// Randomised bench for sample_dma; the bench acts as the Wishbone slave and compares
// every cycle against a queue-based reference model of the buffer writer.
module tb_sample_dma;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          W    = 8;
  localparam int          D    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        s_stb = 1'b0;
  logic [31:0] s_data = '0;
  logic        clr_ovf = 1'b0;
  logic        wb_ack = 1'b0;
  logic        wb_cyc, wb_we, half, wrap, overflow;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat;
  logic [$clog2(W)-1:0] wr_idx;

  always #5 clk = ~clk;

  sample_dma #(
    .BASE      (BASE),
    .WORDS     (W),
    .FIFO_DEPTH(D)
  ) dut (
    .wb_clk  (clk),
    .wb_rst_n(rst_n),
    .enable  (enable),
    .s_stb   (s_stb),
    .s_data  (s_data),
    .clr_ovf (clr_ovf),
    .wb_cyc  (wb_cyc),
    .wb_we   (wb_we),
    .wb_sel  (wb_sel),
    .wb_adr  (wb_adr),
    .wb_dat  (wb_dat),
    .wb_ack  (wb_ack),
    .wr_idx  (wr_idx),
    .half    (half),
    .wrap    (wrap),
    .overflow(overflow)
  );

  int checks = 0;
  int failures = 0;
  int n_half = 0;
  int n_wrap = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted samples wait in a queue; one write is in flight at a time,
  // followed by one mandatory idle cycle before the next write may start.
  logic [31:0] m_q[$];
  bit          m_busy;
  bit          m_cool;
  logic [31:0] m_adr, m_dat;
  int          m_age, m_wait, m_idx;
  bit          m_half, m_wrap, m_ovf;
  int          wait_lo = 0;
  int          wait_hi = 0;
  bit          spur_en = 1'b0;

  function automatic void model_reset();
    m_q.delete();
    m_busy = 0; m_cool = 0; m_adr = '0; m_dat = '0;
    m_age = 0; m_wait = 0; m_idx = 0;
    m_half = 0; m_wrap = 0; m_ovf = 0;
  endfunction

  task automatic model_step(input bit stb, input logic [31:0] d, input bit en, input bit clr,
                            input bit ack);
    bit full;
    bit was_busy;
    full     = (m_q.size() == D);
    was_busy = m_busy;
    m_half   = 0;
    m_wrap   = 0;
    if (m_busy) begin
      if (ack) begin
        m_busy = 0;
        m_half = (m_idx == W / 2 - 1);
        m_wrap = (m_idx == W - 1);
        m_idx  = en ? (m_idx + 1) % W : 0;
        m_cool = 1;
        m_adr  = '0;
        m_dat  = '0;
      end else begin
        m_age++;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (en && m_q.size() > 0) begin
      m_busy = 1;
      m_age  = 0;
      m_dat  = m_q.pop_front();
      m_adr  = BASE + 32'(4 * m_idx);
      m_wait = int'($urandom_range(wait_hi, wait_lo));
    end
    if (!was_busy && !en) m_idx = 0;
    if (stb && en && full) m_ovf = 1;
    else if (clr)          m_ovf = 0;
    if (stb && en && !full) m_q.push_back(d);
    if (!en) m_q.delete();
  endtask

  task automatic check_outputs();
    check_eq("cyc", 32'(wb_cyc), 32'(m_busy));
    check_eq("we", 32'(wb_we), 32'(m_busy));
    check_eq("sel", 32'(wb_sel), m_busy ? 32'hF : 32'h0);
    check_eq("adr", wb_adr, m_adr);
    check_eq("dat", wb_dat, m_dat);
    check_eq("wr_idx", 32'(wr_idx), 32'(m_idx));
    check_eq("half", 32'(half), 32'(m_half));
    check_eq("wrap", 32'(wrap), 32'(m_wrap));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    if (half) n_half++;
    if (wrap) n_wrap++;
  endtask

  // Called at a falling edge: drive inputs, advance the model, check after the next rise.
  task automatic cycle(input bit stb, input logic [31:0] d, input bit en, input bit clr);
    bit ack;
    ack = m_busy ? (m_age >= m_wait) : (spur_en && ($urandom_range(3, 0) == 0));
    s_stb   = stb;
    s_data  = d;
    enable  = en;
    clr_ovf = clr;
    wb_ack  = ack;
    model_step(stb, d, en, clr, ack);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, en, 1'b0);
  endtask

  initial begin
    bit en_r;
    int p;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single write, slave acks one cycle after cyc.
    wait_lo = 1; wait_hi = 1;
    cycle(1'b1, 32'h1234_3456, 1'b1, 1'b0);
    idle(8, 1'b1);
    check_eq("t1_wr_idx", 32'(wr_idx), 32'd1);
    idle(2, 1'b0);

    // Nine spaced writes across the wrap point.
    wait_lo = 0; wait_hi = 0;
    n_half = 0; n_wrap = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
      idle(3, 1'b1);
    end
    idle(4, 1'b1);
    check_eq("t2_half_cnt", 32'(n_half), 32'd1);
    check_eq("t2_wrap_cnt", 32'(n_wrap), 32'd1);
    check_eq("t2_wr_idx", 32'(wr_idx), 32'd1);
    idle(2, 1'b0);

    // Slow slave, six back-to-back strobes: the sixth overflows.
    wait_lo = 10; wait_hi = 10;
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
    check_eq("t3_ovf_set", 32'(overflow), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("t3_ovf_clr", 32'(overflow), 32'd0);
    idle(70, 1'b1);

    // Back-to-back transfers with a zero-wait slave.
    wait_lo = 0; wait_hi = 0;
    cycle(1'b1, 32'h300, 1'b1, 1'b0);
    cycle(1'b1, 32'h301, 1'b1, 1'b0);
    idle(10, 1'b1);

    // Enable dropped mid-transfer with two samples queued.
    wait_lo = 6; wait_hi = 6;
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h400 + 32'(i), 1'b1, 1'b0);
    idle(2, 1'b1);
    idle(25, 1'b0);
    check_eq("t5_wr_idx", 32'(wr_idx), 32'd0);

    // Random traffic with spurious acks outside transfers.
    spur_en = 1'b1;
    en_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      p = (i < 2000) ? 2 : 1;
      wait_lo = 0;
      wait_hi = (i < 2000) ? 3 : 5;
      if ($urandom_range(149, 0) == 0) en_r = ~en_r;
      if (!en_r && $urandom_range(9, 0) == 0) en_r = 1'b1;
      cycle($urandom_range(p, 0) == 0, $urandom, en_r, $urandom_range(15, 0) == 0);
    end
    spur_en = 1'b0;
    idle(2, 1'b0);

    // Reset asserted while a write is on the bus.
    wait_lo = 8; wait_hi = 8;
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    idle(3, 1'b1);
    check_eq("t7_pre_cyc", 32'(wb_cyc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t7_rst_cyc", 32'(wb_cyc), 32'd0);
    check_eq("t7_rst_adr", wb_adr, 32'h0);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    wait_lo = 0; wait_hi = 0;
    cycle(1'b1, 32'h55, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("t7_first_adr", wb_adr, BASE);
    idle(6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
